mem_req_arb: RTL
================

MEM_REQ_ARB -- requirements
Module: mem_req_arb

Interface
REQ-001 Parameter CHN, default 4, number of upstream table-walker channels, legal range 2..8.
REQ-002 Parameter IDW, default 2, upstream request tag width.
REQ-003 Parameter MCNW, default 58, memory cache-line number width.
REQ-004 Parameter DW, default 512, response data width.
REQ-005 Parameter MAXO, default 2, maximum outstanding requests per channel, legal range 1..7.
REQ-006 Derived CW = max(1, clog2(CHN)); downstream tag width TW = CW+IDW.
REQ-007 One clock; reset is synchronous and active-high: clock input 1, sampled on the rising edge only.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 up_req_i_valid  input  CHN  per-channel request valid.
REQ-010 up_req_o_ready  output  CHN  per-channel request accept.
REQ-011 up_req_i_bits_idx  input  CHN*IDW  per-channel tag; channel i occupies slice [i*IDW +: IDW].
REQ-012 up_req_i_bits_mcn  input  CHN*MCNW  per-channel line number, packed the same way.
REQ-013 up_res_o_valid  output  CHN  per-channel response valid.
REQ-014 up_res_i_ready  input  CHN  per-channel response accept.
REQ-015 up_res_o_bits_idx  output  IDW  response tag, shared by all channels.
REQ-016 up_res_o_bits_data  output  DW  response data, shared by all channels.
REQ-017 mem_req_o_valid  output  1  downstream request valid.
REQ-018 mem_req_i_ready  input  1  downstream request accept.
REQ-019 mem_req_o_bits_idx  output  TW  downstream tag = {channel, upstream idx}.
REQ-020 mem_req_o_bits_mcn  output  MCNW  downstream line number.
REQ-021 mem_res_i_valid  input  1  downstream response valid.
REQ-022 mem_res_o_ready  output  1  downstream response accept.
REQ-023 mem_res_i_bits_idx  input  TW  downstream response tag.
REQ-024 mem_res_i_bits_data  input  DW  downstream response data.
REQ-025 err_o  output  1  sticky protocol error flag.
REQ-026 busy_o  output  1  request pending or outstanding.

Function
REQ-027 Output register: the module SHALL hold the downstream request in a single register, holding valid, idx and mcn stable while mem_req_o_valid=1 and mem_req_i_ready=0.
REQ-028 Load enable: the register SHALL load when it is empty or mem_req_i_ready=1 in that cycle.
REQ-029 Eligibility: channel i SHALL be eligible when up_req_i_valid[i]=1 and its outstanding count cnt[i] is less than MAXO.
REQ-030 Grant: when the load enable of REQ-028 holds, exactly one eligible channel SHALL be granted, by round-robin starting at rr_ptr.
REQ-031 Ready: up_req_o_ready SHALL be one-hot of the granted channel, or zero when nothing is granted; it is combinational.
REQ-032 Round-robin pointer: on a grant to channel g, rr_ptr SHALL become (g+1) mod CHN; without a grant, rr_ptr SHALL be unchanged.
REQ-033 Latency: an upstream handshake in cycle N SHALL produce mem_req_o_valid=1 in cycle N+1.
REQ-034 Zero-cycle pass-through: a combinational path from upstream to downstream SHALL NOT exist.
REQ-035 Count increment: cnt[i] SHALL increment on a downstream request handshake carrying channel i.
REQ-036 Count decrement: cnt[i] SHALL decrement on an up_res handshake on channel i.
REQ-037 Simultaneous increment and decrement: when both events hit the same channel in one cycle, cnt[i] SHALL be unchanged.
REQ-038 Response routing: with ch = mem_res_i_bits_idx[TW-1:IDW], up_res_o_valid SHALL be one-hot of ch when mem_res_i_valid=1.
REQ-039 Response tag and data: up_res_o_bits_idx SHALL be the low IDW bits of mem_res_i_bits_idx; data SHALL pass through; mem_res_o_ready SHALL equal up_res_i_ready[ch].
REQ-040 Response pass-through: the response path SHALL be combinational.
REQ-041 Illegal response: a response with ch >= CHN, or with cnt[ch]=0, SHALL be sunk (mem_res_o_ready=1, up_res_o_valid=0) and set err_o.
REQ-042 err_o SHALL stay set until reset.
REQ-043 Counter saturation: cnt[i] SHALL never exceed MAXO and SHALL never wrap below 0.
REQ-044 busy_o SHALL equal mem_req_o_valid OR (any cnt[i] != 0), registered-state derived.

Reset
REQ-045 While reset=1: mem_req_o_valid=0, all cnt=0, rr_ptr=0, err_o=0, up_req_o_ready=0.
REQ-046 Reset mid-operation SHALL discard the pending register and all counts.
REQ-047 Responses arriving after reset for requests issued before it SHALL be treated as illegal per REQ-041.
REQ-048 Reset has priority over all other events in the same cycle.

Verification
REQ-049 Scenario: CHN=4, all channels valid, mem_req_i_ready=1 -> grants go 0,1,2,3,0, one per cycle, each appearing downstream the next cycle.
REQ-050 Scenario: channel 2 issues idx=1, mcn=0x123 with mem_req_i_ready=0 for 5 cycles -> mem_req_o_bits_idx=0b1001 and mcn=0x123 stay stable; up_req_o_ready=0 throughout.
REQ-051 Scenario: MAXO=2, channel 0 issues 2 requests with no responses -> up_req_o_ready[0]=0 while channel 1 is still granted; one response on channel 0 -> channel 0 is eligible again.
REQ-052 Scenario: response tag {ch=3, idx=2} with up_res_i_ready[3]=0 -> mem_res_o_ready=0 and up_res_o_valid=0b1000 held; ready=1 -> handshake, cnt[3] decrements.
REQ-053 Scenario: response tag {ch=1} with cnt[1]=0 -> mem_res_o_ready=1, up_res_o_valid=0, err_o=1 from the next cycle until reset.
REQ-054 Scenario: reset asserted with 3 requests outstanding -> busy_o=0 and mem_req_o_valid=0 on the cycle after reset is sampled.

Source files
------------

// File: rtl/mem_req_arb.sv
// Round-robin arbiter from CHN table-walker channels onto one memory port,
// with per-channel outstanding limits and tag-routed responses.
module mem_req_arb #(
  parameter int CHN  = 4,
  parameter int IDW  = 2,
  parameter int MCNW = 58,
  parameter int DW   = 512,
  parameter int MAXO = 2,
  localparam int CW  = (CHN > 1) ? $clog2(CHN) : 1,
  localparam int TW  = CW + IDW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHN-1:0]      up_req_i_valid,
  output logic [CHN-1:0]      up_req_o_ready,
  input  logic [CHN*IDW-1:0]  up_req_i_bits_idx,
  input  logic [CHN*MCNW-1:0] up_req_i_bits_mcn,
  output logic [CHN-1:0]      up_res_o_valid,
  input  logic [CHN-1:0]      up_res_i_ready,
  output logic [IDW-1:0]      up_res_o_bits_idx,
  output logic [DW-1:0]       up_res_o_bits_data,
  output logic                mem_req_o_valid,
  input  logic                mem_req_i_ready,
  output logic [TW-1:0]       mem_req_o_bits_idx,
  output logic [MCNW-1:0]     mem_req_o_bits_mcn,
  input  logic                mem_res_i_valid,
  output logic                mem_res_o_ready,
  input  logic [TW-1:0]       mem_res_i_bits_idx,
  input  logic [DW-1:0]       mem_res_i_bits_data,
  output logic                err_o,
  output logic                busy_o
);

  logic            vld_q;
  logic [TW-1:0]   idx_q;
  logic [MCNW-1:0] mcn_q;
  logic [CW-1:0]   rr_ptr;
  logic [2:0]      cnt [CHN];
  logic            err_q;

  logic            load_en;
  logic            req_hs;
  logic [CW-1:0]   ch_q;
  logic [CHN-1:0]  elig;
  logic            gnt_vld;
  logic [CW-1:0]   gnt_ch;
  logic [IDW-1:0]  gnt_idx;
  logic [MCNW-1:0] gnt_mcn;
  int              c;

  logic [CW-1:0]   res_ch;
  logic [CHN-1:0]  res_oh;
  logic            res_legal;
  logic            res_rdy;
  logic [CHN-1:0]  inc;
  logic [CHN-1:0]  dec;
  logic            any_cnt;

  assign ch_q    = idx_q[TW-1:IDW];
  assign load_en = !vld_q || mem_req_i_ready;
  assign req_hs  = vld_q && mem_req_i_ready;

  // The request sitting in the output register counts toward its
  // channel's limit, so cnt can never be pushed past MAXO.
  always_comb begin
    for (int i = 0; i < CHN; i++) begin
      elig[i] = up_req_i_valid[i] &&
                (({1'b0, cnt[i]} +
                  {3'b0, (vld_q && ch_q == CW'(i))}) < 4'(MAXO));
    end
  end

  always_comb begin
    c       = 0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    gnt_idx = '0;
    gnt_mcn = '0;
    for (int k = 0; k < CHN; k++) begin
      c = (int'(rr_ptr) + k) % CHN;
      if (!gnt_vld && load_en && !reset && elig[c]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CW'(c);
        gnt_idx = up_req_i_bits_idx[c*IDW +: IDW];
        gnt_mcn = up_req_i_bits_mcn[c*MCNW +: MCNW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHN; i++) begin
      up_req_o_ready[i] = gnt_vld && (gnt_ch == CW'(i));
    end
  end

  assign res_ch = mem_res_i_bits_idx[TW-1:IDW];

  always_comb begin
    res_legal = 1'b0;
    res_rdy   = 1'b1;
    res_oh    = '0;
    for (int i = 0; i < CHN; i++) begin
      if (res_ch == CW'(i)) begin
        res_legal = (cnt[i] != '0);
        res_rdy   = up_res_i_ready[i];
        res_oh[i] = 1'b1;
      end
    end
  end

  assign up_res_o_valid     = (mem_res_i_valid && res_legal) ? res_oh : '0;
  assign mem_res_o_ready    = res_legal ? res_rdy : 1'b1;
  assign up_res_o_bits_idx  = mem_res_i_bits_idx[IDW-1:0];
  assign up_res_o_bits_data = mem_res_i_bits_data;

  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < CHN; i++) begin
      inc[i]  = req_hs && (ch_q == CW'(i));
      dec[i]  = up_res_o_valid[i] && up_res_i_ready[i];
      any_cnt = any_cnt || (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      idx_q  <= '0;
      mcn_q  <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < CHN; i++) cnt[i] <= '0;
    end else begin
      if (load_en) begin
        vld_q <= gnt_vld;
        if (gnt_vld) begin
          idx_q  <= {gnt_ch, gnt_idx};
          mcn_q  <= gnt_mcn;
          rr_ptr <= (gnt_ch == CW'(CHN-1)) ? '0 : gnt_ch + CW'(1);
        end
      end
      if (mem_res_i_valid && !res_legal) err_q <= 1'b1;
      for (int i = 0; i < CHN; i++) begin
        if (inc[i] && !dec[i] && cnt[i] < 3'(MAXO))
          cnt[i] <= cnt[i] + 3'd1;
        else if (dec[i] && !inc[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  assign mem_req_o_valid    = vld_q;
  assign mem_req_o_bits_idx = idx_q;
  assign mem_req_o_bits_mcn = mcn_q;
  assign err_o              = err_q;
  assign busy_o             = vld_q || any_cnt;

endmodule
